// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-channel two-flop synchroniser, stability-counter debouncer, edge pulses, optional toggle latch (SW_TOGGLE_EN)
module switch_debouncer #(
   parameter int N_CH          = 2,
   parameter int STABLE_CYCLES = 1000000,
   parameter int CNT_W         = 20
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] Sw_raw,
   output logic [N_CH-1:0] Sw_clean,
   output logic [N_CH-1:0] Sw_rise,
   output logic [N_CH-1:0] Sw_fall,
   output logic [N_CH-1:0] Sw_toggle
);

   // Last count value before a differing level is accepted.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [N_CH-1:0] sync0;
   logic [N_CH-1:0] sync1;
   logic [N_CH-1:0] clean_d;

   genvar i;
   generate
      for (i = 0; i < N_CH; i++) begin : g_ch
         logic [CNT_W-1:0] cnt;

         // Synchronise the raw pin into the clock domain.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync0[i] <= 1'b0;
               sync1[i] <= 1'b0;
            end else begin
               sync0[i] <= Sw_raw[i];
               sync1[i] <= sync0[i];
            end
         end

         // Accept a new level only after it has differed for STABLE_CYCLES consecutive cycles; any agreement restarts the window.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt         <= '0;
               Sw_clean[i] <= 1'b0;
            end else if (sync1[i] == Sw_clean[i]) begin
               cnt <= '0;
            end else if (cnt == CNT_MAX) begin
               cnt         <= '0;
               Sw_clean[i] <= sync1[i];
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end

         // Registered one-cycle pulses in the cycle after the clean level changes.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               clean_d[i] <= 1'b0;
               Sw_rise[i] <= 1'b0;
               Sw_fall[i] <= 1'b0;
            end else begin
               clean_d[i] <= Sw_clean[i];
               Sw_rise[i] <= Sw_clean[i] & ~clean_d[i];
               Sw_fall[i] <= ~Sw_clean[i] & clean_d[i];
            end
         end

`ifdef SW_TOGGLE_EN
         // Push-on/push-off latch flipped by each rise pulse.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               Sw_toggle[i] <= 1'b0;
            end else if (Sw_rise[i]) begin
               Sw_toggle[i] <= ~Sw_toggle[i];
            end
         end
`else
         assign Sw_toggle[i] = 1'b0;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - directed self-checking bench for switch_debouncer (N_CH=2, STABLE_CYCLES=4, CNT_W=3)
module tb_switch_debouncer;

   logic       clk;
   logic       reset;
   logic [1:0] Sw_raw;
   logic [1:0] Sw_clean;
   logic [1:0] Sw_rise;
   logic [1:0] Sw_fall;
   logic [1:0] Sw_toggle;

   int checks;
   int failures;
   int tcount;
   int nrise;
   int nfall;
   int first_rise;

   logic [2:0] exp_tog [3];
   logic [8:0] bounce;

   switch_debouncer #(
      .N_CH(2),
      .STABLE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .Sw_raw(Sw_raw),
      .Sw_clean(Sw_clean),
      .Sw_rise(Sw_rise),
      .Sw_fall(Sw_fall),
      .Sw_toggle(Sw_toggle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         tcount++;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      tcount   = 0;
      Sw_raw   = 2'b00;
      reset    = 1'b1;

      // Reset state
      #12;
      chk("reset_clean",  32'(Sw_clean),  32'h0);
      chk("reset_rise",   32'(Sw_rise),   32'h0);
      chk("reset_fall",   32'(Sw_fall),   32'h0);
      chk("reset_toggle", 32'(Sw_toggle), 32'h0);
      tick(1);
      reset = 1'b0;
      tick(3);

      // 1: clean step on channel 0, 6-edge latency, rise one edge later
      Sw_raw = 2'b01;
      tick(5);
      chk("t1_clean_before", 32'(Sw_clean), 32'h0);
      tick(1);
      chk("t1_clean_at6", 32'(Sw_clean), 32'h1);
      chk("t1_rise_at6",  32'(Sw_rise),  32'h0);
      tick(1);
      chk("t1_rise_at7",  32'(Sw_rise),  32'h1);
      chk("t1_fall_at7",  32'(Sw_fall),  32'h0);
      tick(1);
      chk("t1_rise_at8",  32'(Sw_rise),  32'h0);
      chk("t1_clean_at8", 32'(Sw_clean), 32'h1);

      // Return channel 0 low, fall pulse timing
      Sw_raw = 2'b00;
      tick(6);
      chk("t1b_clean_at6", 32'(Sw_clean), 32'h0);
      tick(1);
      chk("t1b_fall_at7", 32'(Sw_fall), 32'h1);
      chk("t1b_rise_at7", 32'(Sw_rise), 32'h0);
      tick(3);

      // 2: 3-cycle glitch rejected
      Sw_raw = 2'b01;
      tick(3);
      Sw_raw = 2'b00;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         chk("t2_glitch_quiet", 32'({Sw_clean, Sw_rise, Sw_fall}), 32'h0);
      end

      // 2b: 4-cycle hold accepted, then release also accepted
      nrise = 0;
      nfall = 0;
      Sw_raw = 2'b01;
      for (int k = 0; k < 4; k++) begin
         tick(1);
         nrise += int'(Sw_rise[0]);
         nfall += int'(Sw_fall[0]);
      end
      Sw_raw = 2'b00;
      for (int k = 0; k < 12; k++) begin
         tick(1);
         nrise += int'(Sw_rise[0]);
         nfall += int'(Sw_fall[0]);
      end
      chk("t2_hold_rises", 32'(nrise), 32'd1);
      chk("t2_hold_falls", 32'(nfall), 32'd1);
      chk("t2_hold_clean", 32'(Sw_clean), 32'h0);

      // 3: bounce 1,0,1,1,0,1,1,1,1 then hold on channel 1
      bounce     = 9'b111101101;
      nrise      = 0;
      nfall      = 0;
      first_rise = -1;
      tcount     = 0;
      for (int k = 0; k < 9; k++) begin
         Sw_raw = {bounce[k], 1'b0};
         tick(1);
         if (Sw_rise[1] && first_rise < 0) first_rise = tcount;
         nrise += int'(Sw_rise[1]);
         nfall += int'(Sw_fall[1]);
      end
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (Sw_rise[1] && first_rise < 0) first_rise = tcount;
         nrise += int'(Sw_rise[1]);
         nfall += int'(Sw_fall[1]);
      end
      chk("t3_rises",      32'(nrise),      32'd1);
      chk("t3_falls",      32'(nfall),      32'd0);
      chk("t3_rise_edge",  32'(first_rise), 32'd12);
      chk("t3_clean",      32'(Sw_clean),   32'h2);
      chk("t3_ch0_rise",   32'(Sw_rise[0]), 32'h0);

      // 4: simultaneous steps on both channels
      Sw_raw = 2'b00;
      tick(10);
      chk("t4_clean_zero", 32'(Sw_clean), 32'h0);
      Sw_raw = 2'b11;
      tick(6);
      chk("t4_clean_11", 32'(Sw_clean), 32'h3);
      tick(1);
      chk("t4_rise_11",  32'(Sw_rise), 32'h3);
      chk("t4_fall_00a", 32'(Sw_fall), 32'h0);
      tick(3);
      Sw_raw = 2'b00;
      tick(6);
      chk("t4_clean_00", 32'(Sw_clean), 32'h0);
      tick(1);
      chk("t4_fall_11",  32'(Sw_fall), 32'h3);
      chk("t4_rise_00",  32'(Sw_rise), 32'h0);
      tick(3);

      // 5: async reset mid-qualification
      Sw_raw = 2'b11;
      tick(8);
      chk("t5_pre_clean", 32'(Sw_clean), 32'h3);
      Sw_raw = 2'b01;
      tick(4);
      chk("t5_mid_clean", 32'(Sw_clean), 32'h3);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_clean",  32'(Sw_clean),  32'h0);
      chk("t5_async_rise",   32'(Sw_rise),   32'h0);
      chk("t5_async_fall",   32'(Sw_fall),   32'h0);
      chk("t5_async_toggle", 32'(Sw_toggle), 32'h0);
      Sw_raw = 2'b11;
      tick(2);
      reset = 1'b0;
      tick(5);
      chk("t5_clean_at5", 32'(Sw_clean), 32'h0);
      tick(1);
      chk("t5_clean_at6", 32'(Sw_clean), 32'h3);
      tick(1);
      chk("t5_rise_at7",  32'(Sw_rise),  32'h3);

      // 6: toggle latch over three presses on channel 0
`ifdef SW_TOGGLE_EN
      exp_tog[0] = 3'd1;
      exp_tog[1] = 3'd0;
      exp_tog[2] = 3'd1;
`else
      exp_tog[0] = 3'd0;
      exp_tog[1] = 3'd0;
      exp_tog[2] = 3'd0;
`endif
      reset  = 1'b1;
      Sw_raw = 2'b00;
      tick(1);
      reset = 1'b0;
      tick(3);
      for (int p = 0; p < 3; p++) begin
         Sw_raw = 2'b01;
         tick(8);
         chk($sformatf("t6_toggle_press%0d", p), 32'(Sw_toggle), 32'(exp_tog[p]));
         Sw_raw = 2'b00;
         tick(8);
         chk($sformatf("t6_toggle_release%0d", p), 32'(Sw_toggle), 32'(exp_tog[p]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
